// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: FSM encoding and default sizes.
package pipe_ctrl_pkg;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MD_WAIT  = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam int MD_MAX_CYC_DEF = 40;
  localparam int CNT_W_DEF      = 32;
endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, mul/div and dmem waits.
// Optional stall statistics counter enabled by defining STALL_STATS_EN.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_MAX_CYC = MD_MAX_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_use_haz,
  input  logic             branch_taken_d,
  input  logic             md_req_e,
  input  logic             md_done,
  input  logic             dmem_req_m,
  input  logic             dmem_ready,
  output logic             md_start,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int MDC_W = $clog2(MD_MAX_CYC + 1);

  logic [1:0]       state, state_nxt;
  logic [MDC_W-1:0] md_cnt, md_cnt_nxt;
  logic             tmo_set;
  logic             start_c, sf_c, sd_c, se_c, sm_c, fd_c, fe_c, fm_c;

  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = '0;
    tmo_set    = 1'b0;
    start_c    = 1'b0;
    sf_c       = 1'b0;
    sd_c       = 1'b0;
    se_c       = 1'b0;
    sm_c       = 1'b0;
    fd_c       = 1'b0;
    fe_c       = 1'b0;
    fm_c       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dmem_req_m && !dmem_ready) begin
          {sf_c, sd_c, se_c, sm_c} = 4'b1111;
          state_nxt = ST_MEM_WAIT;
        end else if (md_req_e) begin
          // The start cycle counts as cycle 0 of the mul/div budget.
          start_c    = 1'b1;
          {sf_c, sd_c, se_c, fm_c} = 4'b1111;
          md_cnt_nxt = MDC_W'(1);
          state_nxt  = ST_MD_WAIT;
        end else begin
          if (ld_use_haz) begin
            {sf_c, sd_c, fe_c} = 3'b111;
          end
          // A branch behind a load-use stall re-resolves once the stall clears.
          fd_c = branch_taken_d && !ld_use_haz;
        end
      end
      ST_MD_WAIT: begin
        if (md_done) begin
          state_nxt = ST_IDLE;
        end else if (md_cnt == MDC_W'(MD_MAX_CYC - 1)) begin
          tmo_set   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          {sf_c, sd_c, se_c, fm_c} = 4'b1111;
          md_cnt_nxt = md_cnt + MDC_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = ST_IDLE;
        end else begin
          {sf_c, sd_c, se_c, sm_c} = 4'b1111;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      md_cnt     <= '0;
      md_timeout <= 1'b0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (tmo_set) begin
        md_timeout <= 1'b1;
      end
    end
  end

  assign md_start = start_c & ~rst;
  assign stall_f  = sf_c & ~rst;
  assign stall_d  = sd_c & ~rst;
  assign stall_e  = se_c & ~rst;
  assign stall_m  = sm_c & ~rst;
  assign flush_d  = fd_c & ~rst;
  assign flush_e  = fe_c & ~rst;
  assign flush_m  = fm_c & ~rst;

`ifdef STALL_STATS_EN
  logic stall_any;
  assign stall_any = stall_f | stall_d | stall_e | stall_m;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (stall_any),
    .cnt (stall_cycles)
  );
`else
  assign stall_cycles = '0;
`endif
endmodule
